permute_controller: RTL
=======================

PERMUTE_CONTROLLER -- requirements
Module: permute_controller

Interface
REQ-001 SHALL have parameter NUM_CELLS, default 1600, meaning state bits per permutation (5 rows x 5 columns x 64 pages).
REQ-002 SHALL have parameter CNT_W, default 11, meaning width of internal cell counter (holds NUM_CELLS-1).
REQ-003 SHALL have port clk  in  1  meaning single clock, rising-edge.
REQ-004 SHALL have port rst  in  1  meaning asynchronous, active-high reset.
REQ-005 SHALL have port start  in  1  meaning request a permutation; accepted when start && ready.
REQ-006 SHALL have port data_in  in  NUM_CELLS  meaning source state, sampled on accept.
REQ-007 SHALL have port abort  in  1  meaning cancel an operation in progress.
REQ-008 SHALL have port ack  in  1  meaning consumer has taken the result.
REQ-009 SHALL have port dp_done  in  1  meaning datapath page-counter overflow.
REQ-010 SHALL have port dp_data  out  NUM_CELLS  meaning latched state driven to the datapath.
REQ-011 SHALL have port dp_clr  out  1  meaning one-cycle clear of the datapath counters.
REQ-012 SHALL have port dp_count  out  1  meaning datapath counter enable.
REQ-013 SHALL have port dp_write  out  1  meaning datapath memory write enable.
REQ-014 SHALL have port ready  out  1  meaning idle and able to accept start.
REQ-015 SHALL have port busy  out  1  meaning permutation in progress.
REQ-016 SHALL have port done  out  1  meaning result valid, held until ack.
REQ-017 SHALL have port error  out  1  meaning last run ended with a dp_done/count mismatch.
REQ-018 SHALL have port perm_cnt  out  16  meaning completed error-free permutations, saturating.

Function
REQ-019 SHALL implement FSM states IDLE, CLEAR, RUN and WAIT_ACK, with all control outputs decoded from registered state (Moore).
REQ-020 IDLE: ready=1; on start, SHALL latch data_in into dp_data, clear error, and move to CLEAR; otherwise SHALL stay in IDLE.
REQ-021 CLEAR: dp_clr=1 for exactly one cycle; cell_cnt SHALL be set to 0; next state SHALL be RUN.
REQ-022 RUN: dp_count=1 and dp_write=1 every cycle; cell_cnt SHALL increment by 1 per cycle.
REQ-023 RUN, dp_done=1 and cell_cnt==NUM_CELLS-1: SHALL go to WAIT_ACK with error=0 and increment perm_cnt (saturating at 16'hFFFF).
REQ-024 RUN, dp_done=1 and cell_cnt!=NUM_CELLS-1: SHALL go to WAIT_ACK with error=1; perm_cnt SHALL be unchanged.
REQ-025 RUN, cell_cnt==NUM_CELLS-1 and dp_done=0: SHALL go to WAIT_ACK with error=1; perm_cnt SHALL be unchanged.
REQ-026 WAIT_ACK: done=1; dp_count, dp_write and dp_clr SHALL be 0; on ack SHALL go to IDLE next cycle.
REQ-027 Latency: start accepted at cycle T; CLEAR at T+1; RUN T+2..T+NUM_CELLS+1; done=1 from T+NUM_CELLS+2 (1602 by default).
REQ-028 busy SHALL be 1 in CLEAR and RUN only; ready SHALL be 1 in IDLE only; done SHALL be 1 in WAIT_ACK only.
REQ-029 abort in CLEAR or RUN: SHALL go to IDLE next cycle, with no done, perm_cnt unchanged and error=0; a RUN cycle with abort still counts.
REQ-030 abort SHALL be ignored in IDLE and WAIT_ACK.
REQ-031 abort and dp_done in the same RUN cycle: abort SHALL win.
REQ-032 start in any state other than IDLE SHALL be ignored and not queued.
REQ-033 ack outside WAIT_ACK SHALL be ignored.
REQ-034 dp_data SHALL hold stable from accept until the next accept.
REQ-035 error SHALL remain sticky through WAIT_ACK and IDLE until the next accepted start.

Reset
REQ-036 rst=1 SHALL asynchronously force state=IDLE, dp_data=0, cell_cnt=0, perm_cnt=0, error=0, done=0, busy=0, dp_clr=0, dp_count=0 and dp_write=0.
REQ-037 rst=1 SHALL force ready=1.
REQ-038 rst asserted mid-RUN SHALL discard the operation; perm_cnt SHALL read 0 after release.
REQ-039 After rst release, the first start SHALL be acceptable in the first clock cycle.

Verification
REQ-040 Nominal: start with data_in=pattern A and a model asserting dp_done at cell 1599 -> dp_clr 1 cycle, dp_count high for exactly 1600 cycles, done at T+1602, error=0, perm_cnt=1.
REQ-041 Early done: model asserts dp_done at cell 100 -> WAIT_ACK at the next cycle, error=1, perm_cnt unchanged, dp_count high for 101 cycles.
REQ-042 Missing done: dp_done never asserted -> after 1600 RUN cycles, done=1 and error=1; after ack, ready=1 and error remains 1 until the next start.
REQ-043 Abort at RUN cycle 500 -> IDLE next cycle, no done, error=0; a new start with pattern B completes normally and dp_data=B.
REQ-044 Handshake: start held high during RUN and WAIT_ACK is ignored; ack held off 10 cycles keeps done=1; ack and start in the same cycle -> IDLE, then a new accept.
REQ-045 Reset mid-RUN at cycle 800 -> all outputs at reset values immediately (asynchronous); perm_cnt=0; saturation check: preload 16'hFFFF via 65535 runs or force -> remains 16'hFFFF after the next run.

Source files
------------

// File: rtl/permute_controller.sv
// Sequencing controller for one state permutation: latches the source state, clears the
// datapath counters, runs one write per cell and cross-checks the datapath overflow flag.
module permute_controller #(
  parameter int unsigned NUM_CELLS = 1600,
  parameter int unsigned CNT_W     = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [NUM_CELLS-1:0] data_in,
  input  logic                 abort,
  input  logic                 ack,
  input  logic                 dp_done,
  output logic [NUM_CELLS-1:0] dp_data,
  output logic                 dp_clr,
  output logic                 dp_count,
  output logic                 dp_write,
  output logic                 ready,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [15:0]          perm_cnt
);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StRun,
    StWaitAck
  } state_e;

  localparam logic [CNT_W-1:0] LastCell = CNT_W'(NUM_CELLS - 1);

  state_e           state;
  logic [CNT_W-1:0] cell_cnt;
  logic             last_cell;

  assign last_cell = (cell_cnt == LastCell);

  // Outputs are registered alongside the state, so each transition also loads the
  // output values belonging to the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= StIdle;
      dp_data  <= '0;
      cell_cnt <= '0;
      perm_cnt <= '0;
      error    <= 1'b0;
      done     <= 1'b0;
      busy     <= 1'b0;
      ready    <= 1'b1;
      dp_clr   <= 1'b0;
      dp_count <= 1'b0;
      dp_write <= 1'b0;
    end else begin
      case (state)
        StIdle: begin
          if (start) begin
            dp_data <= data_in;
            error   <= 1'b0;
            ready   <= 1'b0;
            busy    <= 1'b1;
            dp_clr  <= 1'b1;
            state   <= StClear;
          end
        end

        StClear: begin
          dp_clr   <= 1'b0;
          cell_cnt <= '0;
          if (abort) begin
            busy  <= 1'b0;
            ready <= 1'b1;
            error <= 1'b0;
            state <= StIdle;
          end else begin
            dp_count <= 1'b1;
            dp_write <= 1'b1;
            state    <= StRun;
          end
        end

        StRun: begin
          cell_cnt <= cell_cnt + CNT_W'(1);
          if (abort) begin
            // Abort wins over a coincident dp_done; the run is discarded silently.
            busy     <= 1'b0;
            ready    <= 1'b1;
            dp_count <= 1'b0;
            dp_write <= 1'b0;
            error    <= 1'b0;
            state    <= StIdle;
          end else if (dp_done || last_cell) begin
            busy     <= 1'b0;
            dp_count <= 1'b0;
            dp_write <= 1'b0;
            done     <= 1'b1;
            error    <= ~(dp_done & last_cell);
            if (dp_done && last_cell && (perm_cnt != 16'hFFFF)) begin
              perm_cnt <= perm_cnt + 16'd1;
            end
            state    <= StWaitAck;
          end
        end

        StWaitAck: begin
          if (ack) begin
            done  <= 1'b0;
            ready <= 1'b1;
            state <= StIdle;
          end
        end

        default: begin
          state    <= StIdle;
          ready    <= 1'b1;
          busy     <= 1'b0;
          done     <= 1'b0;
          dp_clr   <= 1'b0;
          dp_count <= 1'b0;
          dp_write <= 1'b0;
        end
      endcase
    end
  end

endmodule
